arm_shift_32: RTL and testbench

ARM_SHIFT_32 -- requirements
Module: arm_shift_32

---
 rtl/arm_shift_32.sv | 83 ++++++++
 tb/tb_arm_shift_32.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/arm_shift_32.sv
// arm_shift_32 -- registered ARM-style barrel shifter (LSL/LSR/ASR/ROR/RRX).
//
// Ports:
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous active-high reset
//   carry_in     in   1   current C flag (LSL #0 and RRX)
//   shift_in     in  32   operand
//   shift_amount in   5   shift count 0..31 (0 selects the immediate #0 forms)
//   shift_op     in   2   00 LSL, 01 LSR, 10 ASR, 11 ROR
//   shift_out    out 32   registered result, 1-cycle latency
//   carry_out    out  1   registered shifter carry-out
module arm_shift_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        carry_in,
  input  logic [31:0] shift_in,
  input  logic [4:0]  shift_amount,
  input  logic [1:0]  shift_op,
  output logic [31:0] shift_out,
  output logic        carry_out
);

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  logic        sign;
  logic [31:0] stg [0:5];
  logic [4:0]  idx_r;     // n-1, bit last shifted out on right shifts
  logic [4:0]  idx_l;     // 32-n (mod 32), bit last shifted out on LSL
  logic [31:0] shift_out_d, shift_out_q;
  logic        carry_out_d, carry_out_q;

  assign sign   = shift_in[31];
  assign stg[0] = shift_in;

  // Five cascaded mux stages, stage k shifts by 2^k when shift_amount[k] is set.
  genvar k;
  generate
    for (k = 0; k < 5; k++) begin : g_stage
      localparam int S = 1 << k;
      logic [31:0] shifted;
      assign shifted = (shift_op == OP_LSL) ? {stg[k][31-S:0], {S{1'b0}}}    :
                       (shift_op == OP_LSR) ? {{S{1'b0}}, stg[k][31:S]}      :
                       (shift_op == OP_ASR) ? {{S{sign}}, stg[k][31:S]}      :
                                              {stg[k][S-1:0], stg[k][31:S]};
      assign stg[k+1] = shift_amount[k] ? shifted : stg[k];
    end
  endgenerate

  assign idx_r = shift_amount - 5'd1;
  assign idx_l = 5'd0 - shift_amount;

  // #0 encodings are not "no shift" except for LSL: LSR/ASR #0 mean #32
  // and ROR #0 means RRX, so they bypass the barrel entirely.
  always_comb begin
    shift_out_d = stg[5];
    carry_out_d = (shift_op == OP_LSL) ? shift_in[idx_l] : shift_in[idx_r];
    if (shift_amount == 5'd0) begin
      case (shift_op)
        OP_LSL: begin shift_out_d = shift_in;                    carry_out_d = carry_in;     end
        OP_LSR: begin shift_out_d = 32'h0;                       carry_out_d = sign;         end
        OP_ASR: begin shift_out_d = {32{sign}};                  carry_out_d = sign;         end
        default: begin shift_out_d = {carry_in, shift_in[31:1]}; carry_out_d = shift_in[0]; end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_out_q <= 32'h0;
      carry_out_q <= 1'b0;
    end else begin
      shift_out_q <= shift_out_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign shift_out = shift_out_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_arm_shift_32.sv
module tb_arm_shift_32;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        carry_in = 1'b1;
  logic [31:0] shift_in = 32'hABCDEFAB;
  logic [4:0]  shift_amount = 5'd4;
  logic [1:0]  shift_op = 2'b00;
  logic [31:0] shift_out;
  logic        carry_out;

  int total = 0;
  int bad   = 0;
  logic [32:0] sb [$];   // {carry, out}

  arm_shift_32 dut (
    .clk(clk), .rst(rst), .carry_in(carry_in), .shift_in(shift_in),
    .shift_amount(shift_amount), .shift_op(shift_op),
    .shift_out(shift_out), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  // Reference model written from the ARM shifter definition.
  function automatic logic [32:0] golden(input logic [1:0] op, input logic [4:0] amt,
                                         input logic [31:0] x, input logic cin);
    int n;
    logic [31:0] r;
    logic c;
    n = int'(amt);
    if (n == 0) begin
      case (op)
        2'd0: begin r = x; c = cin; end
        2'd1: begin r = 32'h0; c = x[31]; end
        2'd2: begin r = x[31] ? 32'hFFFFFFFF : 32'h0; c = x[31]; end
        default: begin r = (x >> 1) | (cin ? 32'h80000000 : 32'h0); c = x[0]; end
      endcase
    end else begin
      case (op)
        2'd0: begin r = x << n; c = x[32-n]; end
        2'd1: begin r = x >> n; c = x[n-1]; end
        2'd2: begin r = $unsigned($signed(x) >>> n); c = x[n-1]; end
        default: begin r = (x >> n) | (x << (32-n)); c = x[n-1]; end
      endcase
    end
    return {c, r};
  endfunction

  task automatic test_reset();
    #3;
    total++;
    if ({carry_out, shift_out} !== 33'h0) begin
      bad++;
      $display("FAIL reset_initial got=%h/%b exp=00000000/0", shift_out, carry_out);
    end
    @(posedge clk); #1;
    total++;
    if ({carry_out, shift_out} !== 33'h0) begin
      bad++;
      $display("FAIL reset_held got=%h/%b exp=00000000/0", shift_out, carry_out);
    end
    // First edge sampling rst low must produce LSL #4 of the held inputs.
    @(negedge clk);
    rst = 1'b0;
    sb.push_back({1'b0, 32'hBCDEFAB0});
    @(posedge clk); #1;
    total++;
    if (sb.size() == 0) begin
      bad++; $display("FAIL reset_first scoreboard empty");
    end else begin
      logic [32:0] e;
      e = sb.pop_front();
      if ({carry_out, shift_out} !== e) begin
        bad++;
        $display("FAIL reset_first got=%h/%b exp=%h/%b", shift_out, carry_out, e[31:0], e[32]);
      end
    end
  endtask

  task automatic test_directed();
    logic [1:0]  ops  [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    logic [4:0]  amts [8] = '{5'd0, 5'd4, 5'd0, 5'd8, 5'd0, 5'd4, 5'd0, 5'd8};
    logic [31:0] outs [8] = '{32'hABCDEFAB, 32'hBCDEFAB0, 32'h00000000, 32'h00ABCDEF,
                              32'hFFFFFFFF, 32'hFABCDEFA, 32'hD5E6F7D5, 32'hABABCDEF};
    logic        cs   [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      shift_in = 32'hABCDEFAB; carry_in = 1'b1;
      shift_op = ops[i]; shift_amount = amts[i];
      sb.push_back({cs[i], outs[i]});
      @(posedge clk); #1;
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL directed_%0d scoreboard empty", i);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        if ({carry_out, shift_out} !== e) begin
          bad++;
          $display("FAIL directed_%0d op=%0d amt=%0d got=%h/%b exp=%h/%b",
                   i, ops[i], amts[i], shift_out, carry_out, e[31:0], e[32]);
        end
      end
    end
  endtask

  task automatic test_sweep();
    logic [31:0] opnds [6] = '{32'hABCDEFAB, 32'h80000001, 32'h7FFFFFFE,
                               32'h00000000, 32'hFFFFFFFF, 32'h12345678};
    int sweep_bad;
    sweep_bad = 0;
    opnds[5] = $urandom;
    for (int v = 0; v < 6; v++)
      for (int ci = 0; ci < 2; ci++)
        for (int op = 0; op < 4; op++)
          for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            shift_in = opnds[v]; carry_in = ci[0];
            shift_op = op[1:0]; shift_amount = a[4:0];
            sb.push_back(golden(op[1:0], a[4:0], opnds[v], ci[0]));
            @(posedge clk); #1;
            total++;
            if (sb.size() == 0) begin
              bad++; sweep_bad++; $display("FAIL sweep scoreboard empty");
            end else begin
              logic [32:0] e;
              e = sb.pop_front();
              if ({carry_out, shift_out} !== e) begin
                bad++; sweep_bad++;
                $display("FAIL sweep op=%0d amt=%0d in=%h cin=%0d got=%h/%b exp=%h/%b",
                         op, a, opnds[v], ci, shift_out, carry_out, e[31:0], e[32]);
              end
            end
          end
    if (sweep_bad == 0) $display("Clear");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++) begin
      logic [31:0] x;
      logic [1:0]  op;
      logic [4:0]  a;
      logic        ci;
      x = $urandom; op = 2'($urandom_range(0, 3));
      a = 5'($urandom_range(0, 31)); ci = 1'($urandom_range(0, 1));
      @(negedge clk);
      shift_in = x; carry_in = ci; shift_op = op; shift_amount = a;
      sb.push_back(golden(op, a, x, ci));
      @(posedge clk); #1;
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL b2b scoreboard empty");
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        if ({carry_out, shift_out} !== e) begin
          bad++;
          $display("FAIL b2b op=%0d amt=%0d in=%h cin=%0d got=%h/%b exp=%h/%b",
                   op, a, x, ci, shift_out, carry_out, e[31:0], e[32]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    shift_in = 32'hABCDEFAB; carry_in = 1'b1; shift_op = 2'd0; shift_amount = 5'd0;
    sb.push_back({1'b1, 32'hABCDEFAB});
    @(posedge clk); #1;
    total++;
    begin
      logic [32:0] e;
      e = sb.pop_front();
      if ({carry_out, shift_out} !== e) begin
        bad++;
        $display("FAIL arst_pre got=%h/%b exp=%h/%b", shift_out, carry_out, e[31:0], e[32]);
      end
    end
    // Assert between edges, with a new operation already on the inputs.
    @(negedge clk);
    shift_op = 2'd3; shift_amount = 5'd8;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({carry_out, shift_out} !== 33'h0) begin
      bad++;
      $display("FAIL arst_immediate got=%h/%b exp=00000000/0", shift_out, carry_out);
    end
    @(posedge clk); #1;
    total++;
    if ({carry_out, shift_out} !== 33'h0) begin
      bad++;
      $display("FAIL arst_hold got=%h/%b exp=00000000/0", shift_out, carry_out);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    sb.push_back({1'b1, 32'hABABCDEF});
    @(posedge clk); #1;
    total++;
    begin
      logic [32:0] e;
      e = sb.pop_front();
      if ({carry_out, shift_out} !== e) begin
        bad++;
        $display("FAIL arst_release got=%h/%b exp=%h/%b", shift_out, carry_out, e[31:0], e[32]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_sweep();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
